// File: rtl/mimc_hash_ctrl.sv
// -----------------------------------------------------------------------------
// mimc_hash_ctrl
//
// Purpose:
//   Builds a Miyaguchi-Preneel hash engine around one external MiMC block
//   cipher (exponent 7, BN254 scalar field). Each message block m_i drives
//   one cipher run keyed by the chaining value, and the chain advances as
//     h_i = E_{h_{i-1}}(m_i) + m_i + h_{i-1}  (mod p)
//   After the block flagged msg_last has been absorbed, the digest h is
//   offered on an output channel. The chain then restarts from IV.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   msg_*         message block input channel (valid/ready, data, last flag)
//   hash_*        digest output channel (valid/ready, data)
//   cipher_en     one-cycle start pulse to the cipher
//   cipher_in     plaintext m_i, held stable while the cipher runs
//   cipher_key    key h_{i-1}, held stable while the cipher runs
//   cipher_out    ciphertext, sampled on cipher_done
//   cipher_done   one-cycle completion pulse from the cipher
//   busy          high in every state except IDLE
//   blk_count     blocks absorbed in the current message, saturating
//   proto_err     sticky flag: cipher_done arrived while not waiting for it
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer keeps valid and data stable until that edge, and the
//   consumer may raise or lower ready at any time. msg_ready depends only on
//   the state, and hash_valid/hash_out stay stable until the digest is taken.
// -----------------------------------------------------------------------------
module mimc_hash_ctrl #(
    parameter int                N_BITS  = 254,
    parameter logic [N_BITS-1:0] MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter logic [N_BITS-1:0] IV      = '0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [N_BITS-1:0] msg_data,
    input  logic              msg_last,

    output logic              hash_valid,
    input  logic              hash_ready,
    output logic [N_BITS-1:0] hash_out,

    output logic              cipher_en,
    output logic [N_BITS-1:0] cipher_in,
    output logic [N_BITS-1:0] cipher_key,
    input  logic [N_BITS-1:0] cipher_out,
    input  logic              cipher_done,

    output logic              busy,
    output logic [15:0]       blk_count,
    output logic              proto_err
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ADD1  = 3'd3,
        ADD2  = 3'd4,
        OUT   = 3'd5
    } state_t;

    // state is the single source of truth for the control path. Checkers and
    // waveform views should key off this signal.
    state_t state;
    state_t state_nxt;

    localparam logic [N_BITS:0] MOD_EXT = {1'b0, MODULUS};

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    logic [N_BITS-1:0] h_reg;     // chaining value h_{i-1}, then h_i
    logic [N_BITS-1:0] m_reg;     // reduced message block m_i
    logic [N_BITS-1:0] c_reg;     // ciphertext, then ciphertext + m_i
    logic              last_reg;  // current block closes the message

    // -------------------------------------------------------------------------
    // Field helpers
    // -------------------------------------------------------------------------
    // Both operands are already below p, so their sum is below 2p. A single
    // conditional subtraction is then enough to bring it back into range.
    function automatic logic [N_BITS-1:0] fadd(input logic [N_BITS-1:0] a,
                                               input logic [N_BITS-1:0] b);
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MOD_EXT) begin
            s = s - MOD_EXT;
        end
        return s[N_BITS-1:0];
    endfunction

    // An arbitrary N_BITS input is below 2^254, which is below 2p. One
    // subtraction therefore maps any message word into the field.
    logic [N_BITS-1:0] msg_red;
    assign msg_red = (msg_data >= MODULUS) ? (msg_data - MODULUS) : msg_data;

    // ADD1 and ADD2 both add something to c_reg, and they never run in the
    // same cycle. One modular adder with a muxed second operand covers both:
    //   ADD1: c_reg + m_reg  -> c_reg
    //   ADD2: c_reg + h_reg  -> h_reg
    logic [N_BITS-1:0] add_b;
    logic [N_BITS-1:0] add_sum;
    assign add_b   = (state == ADD1) ? m_reg : h_reg;
    assign add_sum = fadd(c_reg, add_b);

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    logic msg_fire;
    logic hash_fire;
    assign msg_fire  = msg_valid  && msg_ready;
    assign hash_fire = hash_valid && hash_ready;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        msg_ready  = 1'b0;
        hash_valid = 1'b0;
        hash_out   = '0;
        cipher_en  = 1'b0;
        busy       = 1'b1;

        unique case (state)
            IDLE: begin
                msg_ready = 1'b1;
                busy      = 1'b0;
                if (msg_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // The cipher cannot finish in the cycle it is started. A
                // done seen here only raises proto_err and does not advance.
                cipher_en = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cipher_done) begin
                    state_nxt = ADD1;
                end
            end
            ADD1: begin
                state_nxt = ADD2;
            end
            ADD2: begin
                state_nxt = last_reg ? OUT : IDLE;
            end
            OUT: begin
                hash_valid = 1'b1;
                hash_out   = h_reg;
                if (hash_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            h_reg    <= IV;
            m_reg    <= '0;
            c_reg    <= '0;
            last_reg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (msg_fire) begin
                        m_reg    <= msg_red;
                        last_reg <= msg_last;
                    end
                end
                WAIT: begin
                    // The ciphertext is trusted to be already reduced.
                    if (cipher_done) begin
                        c_reg <= cipher_out;
                    end
                end
                ADD1: begin
                    c_reg <= add_sum;
                end
                ADD2: begin
                    h_reg <= add_sum;
                end
                OUT: begin
                    // The next message chains from IV again.
                    if (hash_fire) begin
                        h_reg <= IV;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // m_reg and h_reg change only in IDLE, ADD2 and OUT. That keeps the
    // cipher operands steady for the whole ISSUE/WAIT window without separate
    // output registers.
    assign cipher_in  = m_reg;
    assign cipher_key = h_reg;

    // -------------------------------------------------------------------------
    // Block counter and protocol error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count <= '0;
        end else if (hash_fire) begin
            blk_count <= '0;
        end else if (msg_fire && (blk_count != 16'hFFFF)) begin
            blk_count <= blk_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (cipher_done && (state != WAIT)) begin
            proto_err <= 1'b1;
        end
    end

endmodule
